// File: rtl/lsu_ctrl_rv32i_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_rv32i_if
// Description : Core request/response and data-memory req/ack bundle for the
//               RV32I load/store controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_rv32i_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              stall;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, stall, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, stall, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl_rv32i.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_rv32i
// Description : Multi-cycle RV32I load/store unit; splits word-crossing
//               accesses into two aligned beats and extends load data.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl_rv32i #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  wire logic            clock,
    input  wire logic            reset,
    lsu_ctrl_rv32i_if.slave      bus
);
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_acc1 = 2'd1;
    localparam logic [1:0] c_st_acc2 = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;
    localparam logic [7:0] c_wait_last = 8'(MAX_WAIT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_we;
    logic [2:0]        r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_lo;
    logic [31:0]       r_hi;
    logic              r_err;
    logic [7:0]        r_wait;

    logic              w_illegal;
    logic [1:0]        w_off;
    logic [3:0]        w_mask4;
    logic [7:0]        w_m8;
    logic              w_split;
    logic [63:0]       w_d64;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] w_base;
    logic              w_in_acc;
    logic              w_timeout;

    assign w_illegal = bus.req_we ? (bus.req_type > 3'd2) : (bus.req_type > 3'd4);
    assign w_off     = r_addr[1:0];

    always_comb begin
        case (r_type)
            3'b000, 3'b011: w_mask4 = 4'b0001;
            3'b001, 3'b100: w_mask4 = 4'b0011;
            default:        w_mask4 = 4'b1111;
        endcase
    end

    // Lanes spilling into the upper nibble of the 8-lane mask mean a second beat.
    assign w_m8      = {4'b0000, w_mask4} << w_off;
    assign w_split   = |w_m8[7:4];
    assign w_d64     = {32'h0, r_wdata} << {w_off, 3'b000};
    assign w_word    = 32'({r_hi, r_lo} >> {w_off, 3'b000});
    assign w_base    = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_in_acc  = (r_state == c_st_acc1) || (r_state == c_st_acc2);
    assign w_timeout = w_in_acc && !bus.mem_ack && (r_wait == c_wait_last);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_type  <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_lo    <= 32'h0;
            r_hi    <= 32'h0;
            r_err   <= 1'b0;
            r_wait  <= 8'd0;
        end else begin
            if (r_state == c_st_idle && bus.req_valid) begin
                r_we    <= bus.req_we;
                r_type  <= bus.req_type;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_lo    <= 32'h0;
                r_hi    <= 32'h0;
                r_err   <= w_illegal;
            end
            if (r_state == c_st_acc1 && bus.mem_ack) r_lo <= bus.mem_rdata;
            if (r_state == c_st_acc2 && bus.mem_ack) r_hi <= bus.mem_rdata;
            if (w_timeout) r_err <= 1'b1;
            r_wait <= (w_in_acc && !bus.mem_ack && !w_timeout) ? r_wait + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (bus.req_valid) w_next = w_illegal ? c_st_resp : c_st_acc1;
            c_st_acc1: begin
                if (bus.mem_ack)    w_next = w_split ? c_st_acc2 : c_st_resp;
                else if (w_timeout) w_next = c_st_resp;
            end
            c_st_acc2: if (bus.mem_ack || w_timeout) w_next = c_st_resp;
            default:   w_next = c_st_idle;
        endcase
    end

    // reset gates the IDLE outputs so every output is 0 while reset is held.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.stall      = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_err   = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_be     = 4'b0000;
        bus.mem_wdata  = 32'h0;
        case (r_state)
            c_st_idle: begin
                bus.req_ready = !reset;
                bus.stall     = bus.req_valid && !reset;
            end
            c_st_acc1: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = r_we;
                bus.mem_addr  = w_base;
                bus.mem_be    = w_m8[3:0];
                bus.mem_wdata = w_d64[31:0];
            end
            c_st_acc2: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = r_we;
                bus.mem_addr  = w_base + ADDR_W'(4);
                bus.mem_be    = w_m8[7:4];
                bus.mem_wdata = w_d64[63:32];
            end
            default: begin
                bus.stall      = 1'b1;
                bus.resp_valid = 1'b1;
                bus.resp_err   = r_err;
                if (!r_err && !r_we) begin
                    case (r_type)
                        3'b000:  bus.resp_rdata = {{24{w_word[7]}}, w_word[7:0]};
                        3'b001:  bus.resp_rdata = {{16{w_word[15]}}, w_word[15:0]};
                        3'b011:  bus.resp_rdata = {24'h0, w_word[7:0]};
                        3'b100:  bus.resp_rdata = {16'h0, w_word[15:0]};
                        default: bus.resp_rdata = w_word;
                    endcase
                end
            end
        endcase
    end
endmodule
`default_nettype wire
